hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage datapath (IF, ID, EX, MEM, WB).
- Keeps its own registered shadow of the control fields held by the ID/EX, EX/MEM and MEM/WB buffers.
- From that shadow it produces EX-operand forwarding selects, load-use / RAW stall controls, and the branch flush controls for the buffers.
- Parametrised in register-address width, forwarding mode, WB bypass and counter width; adds saturating stall and flush performance counters.

Parameters:
- RA_W, 5: register address width.
- FWD_EN, 1: 1 = forwarding from MEM/WB, stall only on load-use; 0 = no forwarding, stall on any RAW.
- WB_BYPASS, 1: 1 = register bank writes before it reads in the same cycle, so a WB-stage match is not a hazard when FWD_EN=0.
- CNT_W, 16: performance counter width.

Ports:
- inclk, in, 1: clock, rising edge.
- inrst_n, in, 1: asynchronous reset, active low.
- id_valid, in, 1: a valid instruction occupies ID.
- id_rs, in, RA_W: ID source register rs.
- id_rt, in, RA_W: ID source register rt.
- id_uses_rs, in, 1: ID instruction reads rs.
- id_uses_rt, in, 1: ID instruction reads rt.
- id_dst, in, RA_W: ID destination register (after RegDst select).
- id_regwrite, in, 1: ID instruction writes the register bank.
- id_memread, in, 1: ID instruction is a load.
- br_taken_mem, in, 1: branch in MEM resolved taken.
- stall_pc, out, 1: hold PC.
- stall_ifid, out, 1: hold IF/ID.
- bubble_idex, out, 1: load zeroed controls into ID/EX.
- flush_ifid, out, 1: clear IF/ID.
- flush_idex, out, 1: clear ID/EX.
- flush_exmem, out, 1: clear EX/MEM.
- fwd_a, out, 2: EX operand A select. 00 = bank, 01 = WB, 10 = MEM.
- fwd_b, out, 2: EX operand B select, same encoding.
- stall_cnt, out, CNT_W: cycles stalled.
- flush_cnt, out, CNT_W: taken-branch flush events.

Behaviour:
- Shadow stages EX, MEM, WB each hold {v, rw, mr, dst, rs, rt}. Reset clears every field to 0; all outputs are 0 during and after reset until state changes.
- Each rising edge, normal advance:
  - EX <= ID fields with v = id_valid.
  - MEM <= EX.
  - WB <= MEM.
- A source "matches" stage S when S.v & S.rw & S.dst != 0 & src == S.dst. Register 0 never matches.
- Stall condition, hz:
  - FWD_EN=1: id_valid & EX.v & EX.mr & EX.dst != 0 & ((id_uses_rs & id_rs == EX.dst) | (id_uses_rt & id_rt == EX.dst)).
  - FWD_EN=0: any used ID source matches EX or MEM, or WB when WB_BYPASS=0.
- hz is combinational from shadow state plus ID inputs:
  - stall_pc = stall_ifid = bubble_idex = hz & ~br_taken_mem.
  - On a stall cycle: EX <= bubble (all fields 0), MEM and WB advance normally.
- Flush (br_taken_mem = 1), same cycle:
  - flush_ifid = flush_idex = flush_exmem = 1.
  - On the edge: EX <= 0, MEM <= 0, WB <= MEM.
  - Flush has priority over stall; a simultaneous stall is dropped.
- Forwarding is combinational from EX.rs / EX.rt against the MEM and WB shadows:
  - MEM match gives 10, else WB match gives 01, else 00. MEM wins when both stages match.
  - fwd_a / fwd_b are forced to 00 when FWD_EN=0 or EX.v = 0.
- State machine, for observability; it does not gate any output:
  - RUN: a stall cycle -> STALL; br_taken_mem -> FLUSH.
  - STALL: stays while a stall cycle repeats; br_taken_mem -> FLUSH; else -> RUN.
  - FLUSH: one cycle -> RUN, unless br_taken_mem is asserted again or a stall cycle occurs.
- Counters:
  - stall_cnt +1 on every edge where stall_ifid = 1.
  - flush_cnt +1 on every edge where br_taken_mem = 1.
  - Both saturate at all-ones and never wrap.
- Reset mid-stall or mid-flush: state returns to RUN, shadows and counters go to 0, outputs deassert immediately (asynchronous).
- Latency: a load in EX stalls dependent ID for exactly 1 cycle (FWD_EN=1). With FWD_EN=0 and WB_BYPASS=1, an adjacent dependent instruction stalls 2 cycles.

Test Plan:
- Reset: assert inrst_n=0 mid-stream, with no clock edge -> all outputs 0 immediately; stall_cnt = flush_cnt = 0.
- Load-use, FWD_EN=1: lw to r8 (id_memread=1, dst=8), next ID add uses rs=8 -> stall_pc, stall_ifid and bubble_idex high for exactly 1 cycle; the following cycle fwd_a = 01; stall_cnt = 1.
- Double forward: add r3 then sub r3 then and with rs=3, rt=3 -> when and is in EX, fwd_a = fwd_b = 10 (MEM wins over WB); r0 destinations -> 00.
- No-forward mode, FWD_EN=0, WB_BYPASS=1: add r5 then or with rt=5 -> stall 2 cycles, fwd_b always 00, stall_cnt = 2.
- Branch flush with coincident load-use stall: br_taken_mem=1 -> three flush outputs high, stall outputs 0; flush_cnt +1; the EX and MEM shadows are zero next cycle.
- Saturation, CNT_W=2: 5 stall cycles -> stall_cnt stays 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: keeps a registered shadow of the
// ID/EX, EX/MEM and MEM/WB control fields, and drives stalls, flushes and EX forwarding.
module hazard_ctrl #(
  parameter int RA_W      = 5,
  parameter int FWD_EN    = 1,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             inclk,
  input  logic             inrst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [RA_W-1:0]  id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             br_taken_mem,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic            vld;
    logic            rw;
    logic            mr;
    logic [RA_W-1:0] dst;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
  } ex_shadow_t;

  // MEM and WB are only ever inspected as producers, so they keep just their write identity.
  typedef struct packed {
    logic            vld;
    logic            rw;
    logic [RA_W-1:0] dst;
  } wr_shadow_t;

  state_e           state_q, state_d;
  ex_shadow_t       shd_p0_q, shd_p0_d;
  wr_shadow_t       shd_p1_q, shd_p1_d;
  wr_shadow_t       shd_p2_q, shd_p2_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
  logic load_use, raw_any, hz, stall;

  function automatic logic produces(input wr_shadow_t s, input logic [RA_W-1:0] src);
    return s.vld & s.rw & (s.dst != '0) & (src == s.dst);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    if (en && (cnt != '1)) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  function automatic logic [1:0] fwd_pick(input logic [RA_W-1:0] src,
                                          input wr_shadow_t mem, input wr_shadow_t wb);
    if (produces(mem, src)) return 2'b10;
    if (produces(wb, src))  return 2'b01;
    return 2'b00;
  endfunction

  // Hazard detection against the EX/MEM/WB shadows
  always_comb begin
    rs_ex    = id_uses_rs & produces('{shd_p0_q.vld, shd_p0_q.rw, shd_p0_q.dst}, id_rs);
    rt_ex    = id_uses_rt & produces('{shd_p0_q.vld, shd_p0_q.rw, shd_p0_q.dst}, id_rt);
    rs_mem   = id_uses_rs & produces(shd_p1_q, id_rs);
    rt_mem   = id_uses_rt & produces(shd_p1_q, id_rt);
    rs_wb    = id_uses_rs & produces(shd_p2_q, id_rs);
    rt_wb    = id_uses_rt & produces(shd_p2_q, id_rt);
    load_use = shd_p0_q.vld & shd_p0_q.mr & (shd_p0_q.dst != '0) &
               ((id_uses_rs & (id_rs == shd_p0_q.dst)) |
                (id_uses_rt & (id_rt == shd_p0_q.dst)));
    raw_any  = rs_ex | rt_ex | rs_mem | rt_mem | ((WB_BYPASS == 0) & (rs_wb | rt_wb));
    hz       = id_valid & ((FWD_EN != 0) ? load_use : raw_any);
    stall    = hz & ~br_taken_mem;
  end

  // Shadow advance: a taken branch clears EX and MEM, a stall bubbles EX only
  always_comb begin
    shd_p0_d = '{vld: id_valid, rw: id_regwrite, mr: id_memread,
                 dst: id_dst, rs: id_rs, rt: id_rt};
    shd_p1_d = '{vld: shd_p0_q.vld, rw: shd_p0_q.rw, dst: shd_p0_q.dst};
    shd_p2_d = shd_p1_q;
    if (br_taken_mem) begin
      shd_p0_d = '0;
      shd_p1_d = '0;
    end else if (stall) begin
      shd_p0_d = '0;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if ((FWD_EN != 0) && shd_p0_q.vld) begin
      fwd_a = fwd_pick(shd_p0_q.rs, shd_p1_q, shd_p2_q);
      fwd_b = fwd_pick(shd_p0_q.rt, shd_p1_q, shd_p2_q);
    end
  end

  // Observability FSM; a taken branch always wins over a stall
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (br_taken_mem) state_d = S_FLUSH;
        else if (stall)   state_d = S_STALL;
      end
      S_STALL: begin
        if (br_taken_mem) state_d = S_FLUSH;
        else if (stall)   state_d = S_STALL;
        else              state_d = S_RUN;
      end
      S_FLUSH: begin
        if (br_taken_mem) state_d = S_FLUSH;
        else if (stall)   state_d = S_STALL;
        else              state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, stall);
    flush_cnt_d = sat_inc(flush_cnt_q, br_taken_mem);
  end

  always_ff @(posedge inclk or negedge inrst_n) begin
    if (!inrst_n) begin
      state_q     <= S_RUN;
      shd_p0_q    <= '0;
      shd_p1_q    <= '0;
      shd_p2_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shd_p0_q    <= shd_p0_d;
      shd_p1_q    <= shd_p1_d;
      shd_p2_q    <= shd_p2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_pc    = stall;
  assign stall_ifid  = stall;
  assign bubble_idex = stall;
  assign flush_ifid  = br_taken_mem;
  assign flush_idex  = br_taken_mem;
  assign flush_exmem = br_taken_mem;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
